// File: rtl/jt900h_regbank_if.sv
// Register bank bus: bank pointer commands, two read ports, write, step, clear and dump.
// Purely a signal bundle. It adds no latency.
// There is no backpressure. The clear engine reports busy, and the bank drops commands while busy.
interface jt900h_regbank_if #(
    parameter int BW = 2
);
    logic          cen;
    logic [BW-1:0] rfp;
    logic          rfp_inc;
    logic          rfp_dec;
    logic          rfp_ld;
    logic [BW-1:0] rfp_din;
    logic [7:0]    a_sel;
    logic [31:0]   a_out;
    logic [7:0]    b_sel;
    logic [31:0]   b_out;
    logic [7:0]    w_sel;
    logic [1:0]    w_size;
    logic [31:0]   w_data;
    logic          step_en;
    logic [7:0]    step_sel;
    logic          step_dn;
    logic [1:0]    step_size;
    logic          clr_start;
    logic          busy;
    logic [7:0]    dmp_addr;
    logic [7:0]    dmp_dout;

    modport master (
        output cen, rfp_inc, rfp_dec, rfp_ld, rfp_din, a_sel, b_sel, w_sel, w_size, w_data,
               step_en, step_sel, step_dn, step_size, clr_start, dmp_addr,
        input  rfp, a_out, b_out, busy, dmp_dout
    );

    modport slave (
        input  cen, rfp_inc, rfp_dec, rfp_ld, rfp_din, a_sel, b_sel, w_sel, w_size, w_data,
               step_en, step_sel, step_dn, step_size, clr_start, dmp_addr,
        output rfp, a_out, b_out, busy, dmp_dout
    );
endinterface

// File: rtl/jt900h_regbank.sv
// TLCS-900H register file: NBANK banks of 16 bytes plus four 32-bit pointers, with bank pointer and step unit.
// Read ports and the dump port are registered, with 1 cycle of latency. Read ports forward same-cycle writes and steps.
// No backpressure. While the clear engine runs (busy), commands are dropped and the outputs load zero.
module jt900h_regbank #(
    parameter int NBANK = 4,
    parameter int BW    = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    jt900h_regbank_if.slave  bus
);
    localparam int NL = NBANK * 4 + 4;
    localparam int IW = $clog2(NL);

    typedef enum logic { IDLE = 1'b0, CLEAR = 1'b1 } state_t;

    logic [31:0]   mem     [NL];
    logic [31:0]   mem_nxt [NL];
    state_t        state_q, state_d;
    logic [IW-1:0] cnt_q, cnt_d;
    logic [BW-1:0] rfp_q;
    logic [31:0]   a_q, b_q;
    logic [7:0]    dmp_q;
    logic          busy, act;
    logic [IW:0]   wd, sd, ad, bd, dd;
    logic [3:0]    wmask;
    logic [31:0]   wdat, step_amt, a_rd, b_rd;
    logic [7:0]    dmp_rd;

    assign busy         = (state_q == CLEAR);
    assign act          = bus.cen & ~busy;
    assign bus.busy     = busy;
    assign bus.rfp      = rfp_q;
    assign bus.a_out    = a_q;
    assign bus.b_out    = b_q;
    assign bus.dmp_dout = dmp_q;

    // Map a byte code to {hit, long index}. Bank longs come first, then the four pointers.
    function automatic logic [IW:0] decode(input logic [7:0] code, input logic [BW-1:0] rfp);
        logic [BW-1:0] prv;
        prv    = rfp - 1'b1;
        decode = '0;
        if (int'(code) < NBANK * 16)
            decode = {1'b1, IW'(code[7:2])};
        else if (code[7:4] == 4'hE)
            decode = {1'b1, IW'({rfp, code[3:2]})};
        else if (code[7:4] == 4'hD)
            decode = {1'b1, IW'({prv, code[3:2]})};
        else if (code[7:4] == 4'hF)
            decode = {1'b1, IW'(NBANK * 4) + IW'(code[3:2])};
    endfunction

    // Post-update view of every long. The step applies first, then the written bytes override it.
    always_comb begin
        wd       = decode(bus.w_sel, rfp_q);
        sd       = decode(bus.step_sel, rfp_q);
        wmask    = 4'b0000;
        wdat     = bus.w_data;
        step_amt = 32'd4;
        case (bus.step_size)
            2'b00:   step_amt = 32'd1;
            2'b01:   step_amt = 32'd2;
            default: step_amt = 32'd4;
        endcase
        case (bus.w_size)
            2'b01: begin
                wmask = 4'b0001 << bus.w_sel[1:0];
                wdat  = {4{bus.w_data[7:0]}};
            end
            2'b10: begin
                wmask = bus.w_sel[1] ? 4'b1100 : 4'b0011;
                wdat  = {2{bus.w_data[15:0]}};
            end
            2'b11:   wmask = 4'b1111;
            default: wmask = 4'b0000;
        endcase
        for (int i = 0; i < NL; i++) begin
            mem_nxt[i] = mem[i];
            if (act && bus.step_en && sd[IW] && sd[IW-1:0] == IW'(i))
                mem_nxt[i] = bus.step_dn ? mem[i] - step_amt : mem[i] + step_amt;
            if (act && wd[IW] && wd[IW-1:0] == IW'(i))
                for (int k = 0; k < 4; k++)
                    if (wmask[k]) mem_nxt[i][8*k +: 8] = wdat[8*k +: 8];
        end
    end

    // Read ports see the forwarded longs. The dump port sees storage as it was before this cycle.
    always_comb begin
        ad     = decode(bus.a_sel, rfp_q);
        bd     = decode(bus.b_sel, rfp_q);
        dd     = decode(bus.dmp_addr, rfp_q);
        a_rd   = ad[IW] ? mem_nxt[ad[IW-1:0]] : 32'd0;
        b_rd   = bd[IW] ? mem_nxt[bd[IW-1:0]] : 32'd0;
        dmp_rd = dd[IW] ? mem[dd[IW-1:0]][{bus.dmp_addr[1:0], 3'b000} +: 8] : 8'd0;
    end

    // Clear engine next state. The engine walks every long once, and clr_start is ignored mid-walk.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == CLEAR) begin
            if (cnt_q == IW'(NL - 1)) begin
                state_d = IDLE;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end else if (bus.clr_start) begin
            state_d = CLEAR;
            cnt_d   = '0;
        end
    end

    // Control state and registered outputs. Reset restarts the clear walk.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= CLEAR;
            cnt_q   <= '0;
            rfp_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            dmp_q   <= '0;
        end else if (bus.cen) begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (!busy) begin
                if (bus.rfp_ld)       rfp_q <= bus.rfp_din;
                else if (bus.rfp_dec) rfp_q <= rfp_q - 1'b1;
                else if (bus.rfp_inc) rfp_q <= rfp_q + 1'b1;
            end
            a_q   <= busy ? 32'd0 : a_rd;
            b_q   <= busy ? 32'd0 : b_rd;
            dmp_q <= busy ? 8'd0 : dmp_rd;
        end
    end

    // Storage has no reset. The clear engine zeroes one long per enabled cycle.
    always_ff @(posedge clk) begin
        if (rst_n && bus.cen) begin
            if (busy) mem[cnt_q] <= '0;
            else for (int i = 0; i < NL; i++) mem[i] <= mem_nxt[i];
        end
    end
endmodule

// File: tb/tb_jt900h_regbank.sv
// Directed test of jt900h_regbank with NBANK=4. The test is table driven, with hand sequences for clear, reset and cen.
// Outputs are checked 1ns after the rising edge that registers each vector.
// The only backpressure is busy. Every wait on it is bounded by a cycle budget.
module tb_jt900h_regbank;
    logic clk = 1'b0;
    logic rst_n;
    int   n_vec = 0;
    int   n_err = 0;
    int   n;

    always #5 clk = ~clk;

    jt900h_regbank_if #(.BW(2)) bus ();
    jt900h_regbank #(.NBANK(4), .BW(2)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    typedef struct packed {
        logic [7:0]  a_sel, b_sel, dmp_addr, w_sel;
        logic [1:0]  w_size;
        logic [31:0] w_data;
        logic        step_en;
        logic [7:0]  step_sel;
        logic        step_dn;
        logic [1:0]  step_size;
        logic        rfp_inc, rfp_dec, rfp_ld;
        logic [1:0]  rfp_din;
        logic [3:0]  ck;
        logic [31:0] ea, eb;
        logic [7:0]  ed;
        logic [1:0]  er;
    } vec_t;

    vec_t pre[$];
    vec_t post[$];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        bus.a_sel     = v.a_sel;
        bus.b_sel     = v.b_sel;
        bus.dmp_addr  = v.dmp_addr;
        bus.w_sel     = v.w_sel;
        bus.w_size    = v.w_size;
        bus.w_data    = v.w_data;
        bus.step_en   = v.step_en;
        bus.step_sel  = v.step_sel;
        bus.step_dn   = v.step_dn;
        bus.step_size = v.step_size;
        bus.rfp_inc   = v.rfp_inc;
        bus.rfp_dec   = v.rfp_dec;
        bus.rfp_ld    = v.rfp_ld;
        bus.rfp_din   = v.rfp_din;
    endtask

    task automatic apply(input vec_t v, input string tag, input int idx);
        @(negedge clk);
        drive(v);
        @(posedge clk);
        #1;
        if (v.ck[3]) check($sformatf("%s%0d a_out", tag, idx), bus.a_out, v.ea);
        if (v.ck[2]) check($sformatf("%s%0d b_out", tag, idx), bus.b_out, v.eb);
        if (v.ck[1]) check($sformatf("%s%0d dmp_dout", tag, idx), {24'd0, bus.dmp_dout}, {24'd0, v.ed});
        if (v.ck[0]) check($sformatf("%s%0d rfp", tag, idx), {30'd0, bus.rfp}, {30'd0, v.er});
    endtask

    task automatic count_busy(output int cnt);
        cnt = 0;
        while (bus.busy && cnt < 200) begin
            @(posedge clk);
            #1;
            cnt++;
        end
    endtask

    initial begin
        // Each vector is one cycle. Reads use the bank pointer from before that cycle's update.
        pre.push_back('{a_sel:8'hE0, b_sel:8'hF0, dmp_addr:8'hE0, ck:4'hF, default:'0});
        pre.push_back('{rfp_ld:1'b1, rfp_din:2'd3, ck:4'h1, er:2'd3, default:'0});
        pre.push_back('{w_sel:8'hE4, w_size:2'b11, w_data:32'h12345678, a_sel:8'hE4, b_sel:8'h34, dmp_addr:8'h34,
                        ck:4'hF, ea:32'h12345678, eb:32'h12345678, ed:8'h00, er:2'd3, default:'0});
        pre.push_back('{dmp_addr:8'h34, a_sel:8'h37, rfp_inc:1'b1, ck:4'hB, ea:32'h12345678, ed:8'h78, er:2'd0, default:'0});
        pre.push_back('{dmp_addr:8'h35, a_sel:8'hD4, b_sel:8'hE4, ck:4'hF, ea:32'h12345678, eb:32'h0, ed:8'h56, er:2'd0, default:'0});
        pre.push_back('{dmp_addr:8'h36, ck:4'h2, ed:8'h34, default:'0});
        pre.push_back('{dmp_addr:8'h37, b_sel:8'hD6, ck:4'h6, eb:32'h12345678, ed:8'h12, default:'0});
        pre.push_back('{w_sel:8'hE0, w_size:2'b11, w_data:32'hAABBCCDD, a_sel:8'hE0, ck:4'h8, ea:32'hAABBCCDD, default:'0});
        pre.push_back('{w_sel:8'hE1, w_size:2'b01, w_data:32'hFFFFFF55, a_sel:8'hE0, b_sel:8'h00, dmp_addr:8'hE1,
                        ck:4'hE, ea:32'hAABB55DD, eb:32'hAABB55DD, ed:8'hCC, default:'0});
        pre.push_back('{w_sel:8'hE3, w_size:2'b10, w_data:32'h12349876, a_sel:8'hE0, dmp_addr:8'hE1,
                        ck:4'hA, ea:32'h987655DD, ed:8'h55, default:'0});
        pre.push_back('{w_sel:8'hFC, w_size:2'b11, w_data:32'h00000002, a_sel:8'hFF, ck:4'h8, ea:32'h2, default:'0});
        pre.push_back('{step_en:1'b1, step_sel:8'hFC, step_dn:1'b1, step_size:2'b10, a_sel:8'hFC, dmp_addr:8'hFF,
                        ck:4'hA, ea:32'hFFFFFFFE, ed:8'h00, default:'0});
        pre.push_back('{step_en:1'b1, step_sel:8'hFD, step_size:2'b00, a_sel:8'hFC, dmp_addr:8'hFC,
                        ck:4'hA, ea:32'hFFFFFFFF, ed:8'hFE, default:'0});
        pre.push_back('{step_en:1'b1, step_sel:8'hFC, step_size:2'b01, a_sel:8'hFC, ck:4'h8, ea:32'h00000001, default:'0});
        pre.push_back('{w_sel:8'hF8, w_size:2'b11, w_data:32'h00010000, a_sel:8'hF8, ck:4'h8, ea:32'h00010000, default:'0});
        pre.push_back('{step_en:1'b1, step_sel:8'hF8, step_size:2'b10, w_sel:8'hF8, w_size:2'b10, w_data:32'h0000BEEF,
                        a_sel:8'hF8, b_sel:8'hFA, ck:4'hC, ea:32'h0001BEEF, eb:32'h0001BEEF, default:'0});
        pre.push_back('{dmp_addr:8'hF9, a_sel:8'hF8, ck:4'hA, ea:32'h0001BEEF, ed:8'hBE, default:'0});
        pre.push_back('{step_en:1'b1, step_sel:8'hF0, step_size:2'b11, a_sel:8'hF0, b_sel:8'hF3,
                        ck:4'hC, ea:32'h4, eb:32'h4, default:'0});
        pre.push_back('{w_sel:8'h40, w_size:2'b11, w_data:32'hDEADBEEF, step_en:1'b1, step_sel:8'h50,
                        a_sel:8'h40, b_sel:8'h00, dmp_addr:8'h40, ck:4'hE, ea:32'h0, eb:32'h987655DD, ed:8'h00, default:'0});
        pre.push_back('{a_sel:8'h00, b_sel:8'hCF, dmp_addr:8'h40, ck:4'hE, ea:32'h987655DD, eb:32'h0, ed:8'h00, default:'0});
        pre.push_back('{rfp_ld:1'b1, rfp_din:2'd2, ck:4'h1, er:2'd2, default:'0});
        pre.push_back('{rfp_inc:1'b1, rfp_dec:1'b1, rfp_ld:1'b1, rfp_din:2'd1, ck:4'h1, er:2'd1, default:'0});
        pre.push_back('{rfp_inc:1'b1, rfp_dec:1'b1, ck:4'h1, er:2'd0, default:'0});
        pre.push_back('{rfp_dec:1'b1, ck:4'h1, er:2'd3, default:'0});
        pre.push_back('{rfp_inc:1'b1, ck:4'h1, er:2'd0, default:'0});
        pre.push_back('{rfp_ld:1'b1, rfp_din:2'd2, ck:4'h1, er:2'd2, default:'0});
        pre.push_back('{w_sel:8'hE9, w_size:2'b10, w_data:32'h0000CAFE, a_sel:8'h28, b_sel:8'hD8, dmp_addr:8'h28,
                        ck:4'hF, ea:32'h0000CAFE, eb:32'h0, ed:8'h00, er:2'd2, default:'0});
        pre.push_back('{rfp_inc:1'b1, w_sel:8'hE0, w_size:2'b11, w_data:32'h11111111, a_sel:8'hE0, b_sel:8'h20,
                        ck:4'hD, ea:32'h11111111, eb:32'h11111111, er:2'd3, default:'0});
        pre.push_back('{a_sel:8'h20, b_sel:8'hD0, dmp_addr:8'hD2, ck:4'hF, ea:32'h11111111, eb:32'h11111111,
                        ed:8'h11, er:2'd3, default:'0});

        post.push_back('{a_sel:8'h20, b_sel:8'h00, dmp_addr:8'h34, ck:4'hF, er:2'd3, default:'0});
        post.push_back('{a_sel:8'hFC, b_sel:8'hF8, dmp_addr:8'hE4, ck:4'hF, er:2'd3, default:'0});
        post.push_back('{w_sel:8'h20, w_size:2'b11, w_data:32'h33333333, a_sel:8'h20, ck:4'h9,
                        ea:32'h33333333, er:2'd3, default:'0});

        // Reset, then the power-up clear walk.
        rst_n   = 1'b0;
        bus.cen = 1'b1;
        bus.clr_start = 1'b0;
        drive('0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst busy", {31'd0, bus.busy}, 32'd1);
        check("rst a_out", bus.a_out, 32'd0);
        check("rst b_out", bus.b_out, 32'd0);
        check("rst dmp_dout", {24'd0, bus.dmp_dout}, 32'd0);
        check("rst rfp", {30'd0, bus.rfp}, 32'd0);
        rst_n = 1'b1;
        count_busy(n);
        check("powerup clear cycles", n, 32'd20);

        for (int i = 0; i < pre.size(); i++) apply(pre[i], "v", i);

        // With cen low, nothing moves, including outputs, rfp and storage.
        @(negedge clk);
        bus.cen = 1'b0;
        drive('{w_sel:8'h20, w_size:2'b11, w_data:32'h22222222, rfp_inc:1'b1, a_sel:8'hF8, b_sel:8'hF8,
                dmp_addr:8'hF8, default:'0});
        @(posedge clk);
        #1;
        check("cen0 a_out", bus.a_out, 32'h11111111);
        check("cen0 dmp_dout", {24'd0, bus.dmp_dout}, 32'h11);
        check("cen0 rfp", {30'd0, bus.rfp}, 32'd3);
        @(negedge clk);
        bus.cen = 1'b1;
        drive('{a_sel:8'h20, default:'0});
        @(posedge clk);
        #1;
        check("cen0 write dropped", bus.a_out, 32'h11111111);

        // Software clear. Commands issued during the walk must be dropped.
        @(negedge clk);
        bus.clr_start = 1'b1;
        @(posedge clk);
        #1;
        check("clr start a_out", bus.a_out, 32'h11111111);
        check("clr start busy", {31'd0, bus.busy}, 32'd1);
        drive('{w_sel:8'h00, w_size:2'b11, w_data:32'hFFFFFFFF, step_en:1'b1, step_sel:8'h04, rfp_inc:1'b1,
                a_sel:8'h20, dmp_addr:8'h20, default:'0});
        @(posedge clk);
        #1;
        check("clr a_out zero", bus.a_out, 32'd0);
        check("clr dmp zero", {24'd0, bus.dmp_dout}, 32'd0);
        count_busy(n);
        check("clr cycles", n + 1, 32'd20);
        bus.clr_start = 1'b0;
        drive('0);

        for (int i = 0; i < post.size(); i++) apply(post[i], "p", i);

        // A reset in the middle of a clear restarts the walk from the first long.
        @(negedge clk);
        bus.clr_start = 1'b1;
        @(posedge clk);
        #1;
        bus.clr_start = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("midrst busy", {31'd0, bus.busy}, 32'd1);
        check("midrst rfp", {30'd0, bus.rfp}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        count_busy(n);
        check("midrst clear cycles", n, 32'd20);
        apply('{a_sel:8'h20, ck:4'h9, default:'0}, "r", 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/jt900h_regbank.md
Name: jt900h_regbank

Overview:
- Parametrised successor to the TLCS-900H register file.
- Holds NBANK banks of 16 bytes each (XWA/XBC/XDE/XHL) plus four 32-bit pointer registers (XIX/XIY/XIZ/XSP).
- Features: bank pointer, two registered read ports with write forwarding, byte/word/long writes, pointer step unit for (R+)/(-R) addressing, and a hardware clear engine in place of a flop-array reset.
- Sits between the instruction decoder/ALU and the memory addresser; a byte-wide dump port feeds the debug bus.

Parameters:
NBANK, 4, number of register banks; power of two, 2..8
BW, 2, bank pointer width; must equal log2(NBANK)

Ports:
clk  input  1  system clock
rst_n  input  1  synchronous active-low reset
cen  input  1  clock enable; all state advances only when high
rfp  output  BW  current bank pointer
rfp_inc  input  1  increment bank pointer
rfp_dec  input  1  decrement bank pointer
rfp_ld  input  1  load bank pointer from rfp_din
rfp_din  input  BW  bank pointer load value
a_sel  input  8  read port A register code
a_out  output  32  read port A data, registered
b_sel  input  8  read port B register code
b_out  output  32  read port B data, registered
w_sel  input  8  write register code
w_size  input  2  00 none, 01 byte, 10 word, 11 long
w_data  input  32  write data, LSB-aligned
step_en  input  1  apply pointer step
step_sel  input  8  register code of the stepped long register
step_dn  input  1  0 add step, 1 subtract step
step_size  input  2  00 → 1, 01 → 2, 10 → 4, 11 → 4
clr_start  input  1  start clear engine
busy  output  1  clear engine active
dmp_addr  input  8  dump byte address (same code space)
dmp_dout  output  8  dump byte, registered

Behaviour:
- Register code decode (byte granularity):
  - 0x00..NBANK*16-1: absolute bank byte.
  - 0xE0-0xEF: current bank (rfp).
  - 0xD0-0xDF: previous bank (rfp-1 mod NBANK; rfp=0 → NBANK-1).
  - 0xF0-0xFF: pointer bytes, 0xF0 = XIX LSB.
  - All other codes are unmapped: read 0, writes/steps ignored.
  - Current/previous resolve with rfp as it is before that cycle's update.
- Alignment: word accesses ignore code bit0; long accesses ignore bits[1:0]. Reads always return the aligned long containing the code; byte lanes are little-endian.
- Reads: a_out/b_out update on cen with 1-cycle latency.
  - Forwarding: if a write, or a step, hits the same long in that cycle, the output shows post-update bytes.
- Write: only the bytes selected by w_size change. Byte writes use w_data[7:0] at the code's byte; word writes use [15:0].
- Step: the long at step_sel becomes old ± step, modulo 2^32.
  - If a write hits the same long in the same cycle, the step applies first and the written bytes then override.
- rfp: priority rfp_ld > rfp_dec > rfp_inc; wraps modulo NBANK.
- Clear engine FSM, states CLEAR and IDLE:
  - rst_n low forces CLEAR with counter = 0.
  - CLEAR zeroes one long per cen cycle: bank longs 0..NBANK*4-1, then the 4 pointers.
  - Total NBANK*4+4 cen cycles, then go to IDLE.
  - clr_start in IDLE enters CLEAR on the next cen; clr_start during CLEAR is ignored and does not restart the counter.
  - While busy: writes, steps and rfp commands are ignored; a_out, b_out and dmp_dout load 0.
- Reset values: rfp=0, a_out=0, b_out=0, dmp_dout=0, busy=1. Storage is not reset directly; the clear engine zeroes it.
- Reset asserted mid-clear or mid-operation: the engine restarts from counter 0 and rfp returns to 0.
- cen low: no state, output or counter changes.
- Dump: dmp_dout = byte at dmp_addr, decoded as above (current/previous included), 1-cycle latency, no forwarding; unmapped codes return 0.

Test Plan:
1. Release reset with NBANK=4, cen=1 → busy high for exactly 20 cycles, then low. Reading 0xE0 and 0xF0 then gives 0.
2. rfp_ld with rfp_din=3, then long write 0xE4 = 0x12345678 → dump of 0x34..0x37 gives 78,56,34,12. Read of 0xD4 after rfp_inc (rfp wraps to 0) returns 0x12345678.
3. Write long 0xE0 = 0xAABBCCDD, then byte write 0xE1 = 0x55 with a_sel=0xE0 in the same cycle → a_out = 0xAABB55DD on the next cycle (forwarding).
4. XSP = 0x00000002, step_en, step_dn=1, step_size=10 on 0xFC → XSP = 0xFFFFFFFE. Same with step_dn=0 and step_size=00 → 0xFFFFFFFF.
5. Same-cycle step +4 and word write 0xF8 = 0xBEEF on XIZ = 0x00010000 → XIZ = 0x0001BEEF.
6. rfp_inc, rfp_dec and rfp_ld (din=1) together at rfp=2 → rfp=1. clr_start mid-run → busy for 20 cycles, all registers 0, and writes issued while busy are dropped.
